// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one 32-bit ALU between two valid/ready requesters.
// Grants in IDLE, executes for one cycle, then holds a tagged response until consumed.

module alu #(
    parameter int unsigned W = 32
) (
    input  logic [2:0]   opsel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         err
);

    localparam logic [2:0] OPSEL_NONE = 3'd0;
    localparam logic [2:0] OPSEL_AND  = 3'd1;
    localparam logic [2:0] OPSEL_OR   = 3'd2;
    localparam logic [2:0] OPSEL_XOR  = 3'd3;
    localparam logic [2:0] OPSEL_NEG  = 3'd4;
    localparam logic [2:0] OPSEL_ADD  = 3'd5;
    localparam logic [2:0] OPSEL_SUB  = 3'd6;

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (opsel)
            OPSEL_AND: y = a & b;
            OPSEL_OR:  y = a | b;
            OPSEL_XOR: y = a ^ b;
            OPSEL_NEG: y = ~a;
            OPSEL_ADD: y = a + b;
            OPSEL_SUB: y = a - b;
            OPSEL_NONE: err = 1'b1;
            default:   err = 1'b1;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_opsel,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_opsel,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_err,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]   state;
    logic         last_grant;
    logic [W-1:0] lat_a;
    logic [W-1:0] lat_b;
    logic [2:0]   lat_opsel;
    logic         lat_id;

    logic         gnt0;
    logic         gnt1;
    logic [W-1:0] alu_y;
    logic         alu_err;

    logic         rsp_id_q;
    logic [W-1:0] rsp_result_q;
    logic         rsp_err_q;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    alu #(
        .W(W)
    ) u_alu (
        .opsel(lat_opsel),
        .a    (lat_a),
        .b    (lat_b),
        .y    (alu_y),
        .err  (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            lat_a        <= '0;
            lat_b        <= '0;
            lat_opsel    <= '0;
            lat_id       <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        lat_a      <= gnt1 ? req1_a : req0_a;
                        lat_b      <= gnt1 ? req1_b : req0_b;
                        lat_opsel  <= gnt1 ? req1_opsel : req0_opsel;
                        lat_id     <= gnt1;
                        last_grant <= gnt1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_id_q     <= lat_id;
                    rsp_err_q    <= alu_err;
                    rsp_result_q <= alu_err ? '0 : alu_y;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid  = (state == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model evaluated every cycle.

module tb_alu_arbiter;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NEG  = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_BAD  = 3'd7;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_opsel, req1_opsel;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_result;

    alu_arbiter #(
        .W(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_opsel(req0_opsel),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_opsel(req1_opsel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference result: {err, result}
    function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NEG:  return {1'b0, ~a};
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return {1'b0, a - b};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Model: unit is free, or holds one accepted op for an exec cycle, then until consumed.
    int          m_phase;
    int          m_last;
    int          m_win;
    logic        m_id;
    logic [32:0] m_out;
    int          cyc = 0;
    int          q_id[$];
    int          q_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_phase = 0;
            m_last  = 1;
            check_val("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            check_val("rst_busy", {31'h0, busy}, 32'h0);
            check_val("rst_rsp_id", {31'h0, rsp_id}, 32'h0);
            check_val("rst_rsp_result", rsp_result, 32'h0);
            check_val("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        end else begin
            m_win = -1;
            if (m_phase == 0) begin
                if (req0_valid && req1_valid) m_win = 1 - m_last;
                else if (req0_valid)          m_win = 0;
                else if (req1_valid)          m_win = 1;
            end
            check_val("ready0", {31'h0, req0_ready}, (m_win == 0) ? 32'h1 : 32'h0);
            check_val("ready1", {31'h0, req1_ready}, (m_win == 1) ? 32'h1 : 32'h0);
            check_val("busy", {31'h0, busy}, (m_phase != 0) ? 32'h1 : 32'h0);
            check_val("rsp_valid", {31'h0, rsp_valid}, (m_phase == 2) ? 32'h1 : 32'h0);
            if (m_phase == 2) begin
                check_val("rsp_id", {31'h0, rsp_id}, {31'h0, m_id});
                check_val("rsp_result", rsp_result, m_out[31:0]);
                check_val("rsp_err", {31'h0, rsp_err}, {31'h0, m_out[32]});
            end
            case (m_phase)
                0: if (m_win >= 0) begin
                    m_id    = (m_win == 1);
                    m_out   = (m_win == 1) ? ref_op(req1_opsel, req1_a, req1_b)
                                           : ref_op(req0_opsel, req0_a, req0_b);
                    m_last  = m_win;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (rsp_ready) begin
                    q_id.push_back(int'(rsp_id));
                    q_cyc.push_back(cyc);
                    m_phase = 0;
                end
            endcase
        end
    end

    task automatic set_req(input int id, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 1) begin
            req1_valid = v; req1_opsel = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_opsel = op; req0_a = a; req0_b = b;
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 1) ? req1_ready : req0_ready;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        set_req(0, 1'b0, OP_NONE, 32'h0, 32'h0);
        set_req(1, 1'b0, OP_NONE, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_val("async_busy", {31'h0, busy}, 32'h0);
        check_val("async_rsp_result", rsp_result, 32'h0);
        check_val("async_rsp_err", {31'h0, rsp_err}, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Issue one op and wait for its response; lat counts cycles from ready to rsp_valid.
    task automatic run_op(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic err, output logic rid, output int lat);
        bit got;
        @(posedge clk);
        #1;
        set_req(id, 1'b1, op, a, b);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rdy(id)) got = 1;
        end
        if (!got) check_val("hs_timeout", {31'h0, rdy(id)}, 32'h1);
        @(posedge clk);
        #1;
        set_req(id, 1'b0, op, a, b);
        lat = 0;
        got = 0;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                lat = k;
            end
        end
        if (!got) check_val("rsp_timeout", {31'h0, rsp_valid}, 32'h1);
        res = rsp_result;
        err = rsp_err;
        rid = rsp_id;
    endtask

    logic [31:0] r, r_hold;
    logic        e, id, e_hold, id_hold;
    int          lat;
    bit          h0, h1, got;

    initial begin
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b0, OP_NONE, 32'h0, 32'h0);
        set_req(1, 1'b0, OP_NONE, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // First op after reset, plus mid-cycle async reset
        run_op(0, OP_ADD, 32'd5, 32'd7, r, e, id, lat);
        check_val("add_res", r, 32'd12);
        check_val("add_id", {31'h0, id}, 32'h0);
        check_val("add_err", {31'h0, e}, 32'h0);
        check_val("add_lat", lat, 32'd2);
        do_reset();

        run_op(1, OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F01, r, e, id, lat);
        check_val("sweep_and", r, 32'h00F0_0001);
        check_val("sweep_id", {31'h0, id}, 32'h1);
        run_op(1, OP_OR, 32'hF0F0_00FF, 32'h0FF0_0F01, r, e, id, lat);
        check_val("sweep_or", r, 32'hFFF0_0FFF);
        run_op(1, OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F01, r, e, id, lat);
        check_val("sweep_xor", r, 32'hFF00_0FFE);
        run_op(1, OP_NEG, 32'hF0F0_00FF, 32'h0FF0_0F01, r, e, id, lat);
        check_val("sweep_neg", r, 32'h0F0F_FF00);
        run_op(1, OP_ADD, 32'hF0F0_00FF, 32'h0FF0_0F01, r, e, id, lat);
        check_val("sweep_add", r, 32'h00E0_1000);
        // 0xF0F000FF - 0x0FF00F01 = 0xE0FFF1FE (borrow out of the low half)
        run_op(1, OP_SUB, 32'hF0F0_00FF, 32'h0FF0_0F01, r, e, id, lat);
        check_val("sweep_sub", r, 32'hE0FF_F1FE);

        run_op(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, r, e, id, lat);
        check_val("wrap_add", r, 32'h0);
        run_op(0, OP_SUB, 32'h0, 32'd1, r, e, id, lat);
        check_val("wrap_sub", r, 32'hFFFF_FFFF);

        run_op(0, OP_NONE, 32'h1234, 32'h5678, r, e, id, lat);
        check_val("none_err", {31'h0, e}, 32'h1);
        check_val("none_res", r, 32'h0);
        run_op(1, OP_BAD, 32'h1234, 32'h5678, r, e, id, lat);
        check_val("undef_err", {31'h0, e}, 32'h1);
        check_val("undef_res", r, 32'h0);

        // Contention from reset
        do_reset();
        @(posedge clk);
        #1;
        q_id.delete();
        q_cyc.delete();
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        set_req(1, 1'b1, OP_XOR, 32'd3, 32'd5);
        repeat (19) @(posedge clk);
        #1;
        set_req(0, 1'b0, OP_ADD, 32'd1, 32'd2);
        set_req(1, 1'b0, OP_XOR, 32'd3, 32'd5);
        repeat (6) @(posedge clk);
        check_val("cont_count_ge6", (q_id.size() >= 6) ? 32'h1 : 32'h0, 32'h1);
        if (q_id.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check_val($sformatf("cont_id%0d", i), q_id[i], i % 2);
                if (i > 0) check_val($sformatf("cont_gap%0d", i), q_cyc[i] - q_cyc[i-1], 32'd3);
            end
        end

        // Back-pressure, with requester 1 waiting meanwhile
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        set_req(0, 1'b1, OP_SUB, 32'd100, 32'd58);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req0_ready) got = 1;
        end
        if (!got) check_val("bp_hs_timeout", {31'h0, req0_ready}, 32'h1);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, OP_NONE, 32'h0, 32'h0);
        set_req(1, 1'b1, OP_OR, 32'h0F, 32'hF0);
        @(negedge clk);
        @(negedge clk);
        check_val("bp_valid", {31'h0, rsp_valid}, 32'h1);
        r_hold = rsp_result;
        id_hold = rsp_id;
        e_hold = rsp_err;
        check_val("bp_res", r_hold, 32'd42);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("bp_stable_res", rsp_result, r_hold);
            check_val("bp_stable_id", {31'h0, rsp_id}, {31'h0, id_hold});
            check_val("bp_stable_err", {31'h0, rsp_err}, {31'h0, e_hold});
            check_val("bp_busy", {31'h0, busy}, 32'h1);
            check_val("bp_ready", {30'h0, req0_ready, req1_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("bp_released", {31'h0, rsp_valid}, 32'h0);
        check_val("bp_next_grant", {31'h0, req1_ready}, 32'h1);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, OP_NONE, 32'h0, 32'h0);
        repeat (4) @(posedge clk);

        // Abort during EXEC
        @(posedge clk);
        #1;
        set_req(0, 1'b1, OP_ADD, 32'd9, 32'd9);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req0_ready) got = 1;
        end
        if (!got) check_val("abort_hs_timeout", {31'h0, req0_ready}, 32'h1);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, OP_NONE, 32'h0, 32'h0);
        check_val("abort_in_exec", {31'h0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        set_req(0, 1'b1, OP_XOR, 32'hAA, 32'hFF);
        set_req(1, 1'b1, OP_AND, 32'hAA, 32'hFF);
        @(negedge clk);
        check_val("abort_tie", {30'h0, req1_ready, req0_ready}, 32'h1);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, OP_NONE, 32'h0, 32'h0);
        set_req(1, 1'b0, OP_NONE, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check_val("abort_next_res", rsp_result, 32'h55);
        check_val("abort_next_id", {31'h0, rsp_id}, 32'h0);
        repeat (2) @(posedge clk);

        // Random traffic; the per-cycle model checks everything
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (h0 || !req0_valid)
                set_req(0, ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom);
            if (h1 || !req1_valid)
                set_req(1, ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        set_req(0, 1'b0, OP_NONE, 32'h0, 32'h0);
        set_req(1, 1'b0, OP_NONE, 32'h0, 32'h0);
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
